// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path: frame-alignment states, pixel width
// helper and the default fill colour.
package vga_pkg;

   typedef enum logic [1:0] {
      RESYNC     = 2'd0,
      WAIT_FRAME = 2'd1,
      STREAM     = 2'd2
   } state_t;

   localparam int DEFAULT_CHANNEL_BITS = 4;
   localparam logic [11:0] FILL_COLOR_DEFAULT = 12'hF0F;

   function automatic int pixel_width(input int channel_bits);
      return 3 * channel_bits;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with a separate occupancy counter; pushes are dropped
// when full, pops ignored when empty, and the head entry is visible combinationally.
module sync_fifo #(
   parameter int WIDTH     = 13,
   parameter int DEPTH     = 16,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [WIDTH-1:0]     wdata,
   output logic [WIDTH-1:0]     rdata,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_BITS:0]   level
);

   localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr;
   logic [ADDR_BITS-1:0] rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (level == FULL_LEVEL);
   assign empty   = (level == {(ADDR_BITS + 1){1'b0}});
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage array; stale contents are harmless because level gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= {ADDR_BITS{1'b0}};
         rd_ptr <= {ADDR_BITS{1'b0}};
         level  <= {(ADDR_BITS + 1){1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ADDR_BITS'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ADDR_BITS'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + (ADDR_BITS + 1)'(1);
            2'b01:   level <= level - (ADDR_BITS + 1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel elastic buffer feeding the VGA timing stage, with start-of-frame alignment
// and fill-colour substitution. Optional macro VGA_PIXEL_FIFO_STATS_EN adds underflow_count.
module vga_pixel_fifo
   import vga_pkg::*;
#(
   parameter int CHANNEL_BITS = DEFAULT_CHANNEL_BITS,
   parameter int DEPTH        = 16,
   parameter int ADDR_BITS    = 4,
   parameter logic [3*CHANNEL_BITS-1:0] FILL_COLOR = FILL_COLOR_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [3*CHANNEL_BITS-1:0]  s_pixel,
   input  logic                       s_sof,
   input  logic                       pixel_req,
   input  logic                       frame_start,
   output logic [3*CHANNEL_BITS-1:0]  pixel_out,
   output logic                       underflow,
   output logic [ADDR_BITS:0]         level
`ifdef VGA_PIXEL_FIFO_STATS_EN
   ,
   output logic [15:0]                underflow_count
`endif
);

   localparam int PW = pixel_width(CHANNEL_BITS);

   state_t          state;
   state_t          next_state;
   logic [PW:0]     head;
   logic            head_sof;
   logic [PW-1:0]   head_pixel;
   logic [PW-1:0]   next_pixel;
   logic            full;
   logic            empty;
   logic            pop;
   logic            err;

   assign head_sof   = head[PW];
   assign head_pixel = head[PW-1:0];
   assign s_ready    = !full && !reset;

   sync_fifo #(
      .WIDTH     (PW + 1),
      .DEPTH     (DEPTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (s_valid),
      .pop   (pop),
      .wdata ({s_sof, s_pixel}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Alignment decisions: frame_start checks outrank the ordinary pop rule.
   always_comb begin
      next_state = state;
      next_pixel = {PW{1'b0}};
      pop        = 1'b0;
      err        = 1'b0;
      case (state)
         RESYNC: begin
            if (!empty) begin
               if (head_sof) begin
                  next_state = WAIT_FRAME;
               end else begin
                  pop = 1'b1;
               end
            end else begin
               next_state = RESYNC;
            end
            if (pixel_req) begin
               next_pixel = FILL_COLOR;
            end else begin
               next_pixel = {PW{1'b0}};
            end
         end
         WAIT_FRAME: begin
            if (pixel_req && frame_start) begin
               pop        = 1'b1;
               next_pixel = head_pixel;
               next_state = STREAM;
            end else if (pixel_req) begin
               next_pixel = FILL_COLOR;
            end else begin
               next_pixel = {PW{1'b0}};
            end
         end
         STREAM: begin
            if (!pixel_req) begin
               next_pixel = {PW{1'b0}};
            end else if (empty) begin
               next_pixel = FILL_COLOR;
               err        = 1'b1;
               next_state = RESYNC;
            end else if (frame_start) begin
               if (head_sof) begin
                  pop        = 1'b1;
                  next_pixel = head_pixel;
               end else begin
                  next_pixel = FILL_COLOR;
                  err        = 1'b1;
                  next_state = RESYNC;
               end
            end else if (head_sof) begin
               // Renderer frame ended early: hold its next frame until the timing stage catches up.
               next_pixel = FILL_COLOR;
               err        = 1'b1;
               next_state = WAIT_FRAME;
            end else begin
               pop        = 1'b1;
               next_pixel = head_pixel;
            end
         end
         default: begin
            next_state = RESYNC;
            next_pixel = {PW{1'b0}};
         end
      endcase
   end

   // State, registered pixel output and sticky underflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RESYNC;
         pixel_out <= {PW{1'b0}};
         underflow <= 1'b0;
      end else begin
         state     <= next_state;
         pixel_out <= next_pixel;
         underflow <= underflow | err;
      end
   end

`ifdef VGA_PIXEL_FIFO_STATS_EN
   // Saturating count of error-driven fill cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underflow_count <= 16'h0000;
      end else if (err && (underflow_count != 16'hFFFF)) begin
         underflow_count <= underflow_count + 16'h0001;
      end else begin
         underflow_count <= underflow_count;
      end
   end
`endif

endmodule

// File: doc/vga_pixel_fifo.md
Name: vga_pixel_fifo

Overview:
- Pixel elastic buffer directly upstream of the vga timing/colour stage. It replaces the static switch colour with a streamed frame.
- Accepts RGB pixels from the renderer over a valid/ready handshake, stores them in a single-clock FIFO, and pops one pixel per visible-area request from the timing stage.
- Enforces frame alignment using a start-of-frame tag, and substitutes a fill colour on underflow or misalignment.

Parameters:
- CHANNEL_BITS, 4, bits per colour channel; pixel width is 3*CHANNEL_BITS.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- ADDR_BITS, 4, log2(DEPTH).
- FILL_COLOR, 12'hF0F, pixel emitted on underflow or misalignment; width 3*CHANNEL_BITS.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  renderer pixel valid.
- s_ready  out  1  FIFO can accept a pixel.
- s_pixel  in  3*CHANNEL_BITS  {R,G,B}, R in the MSBs.
- s_sof  in  1  marks the first pixel of a frame.
- pixel_req  in  1  timing stage is in the visible area this cycle.
- frame_start  in  1  high together with pixel_req on the first visible pixel of a frame.
- pixel_out  out  3*CHANNEL_BITS  registered pixel to the timing stage.
- underflow  out  1  sticky error flag; cleared only by reset.
- level  out  ADDR_BITS+1  current occupancy, 0..DEPTH.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: wr/rd pointers 0, level 0, state RESYNC, pixel_out 0, underflow 0. s_ready is 0 while reset is high.
- Storage: each entry holds {sof, pixel}. Pointers are ADDR_BITS wide and wrap DEPTH-1 -> 0. level is tracked in a separate counter.
- Write: occurs when s_valid && s_ready. s_ready = (level != DEPTH), combinational from the current level.
  - A pop in the same cycle does not raise s_ready in that cycle.
  - Simultaneous push and pop leaves level unchanged.
- Read side: pixel_out is registered with 1-cycle latency from pixel_req.
  - pixel_req=0 -> pixel_out=0 (blank) next cycle.
  - No bypass: a push into an empty FIFO is not visible to a pop in the same cycle.
- State machine:
  - RESYNC: if the FIFO is non-empty and head.sof=0, pop one entry per cycle (discard). If head.sof=1 -> WAIT_FRAME. Any pixel_req in this state outputs FILL_COLOR.
  - WAIT_FRAME: no pops. pixel_req without frame_start outputs FILL_COLOR. On frame_start && pixel_req: pop the head, output its pixel, -> STREAM.
  - STREAM, on pixel_req:
    - Non-empty, head.sof=0, frame_start=0: pop and output the head pixel.
    - Empty: output FILL_COLOR, set underflow, -> RESYNC.
    - head.sof=1 with frame_start=0 (renderer frame too short): output FILL_COLOR, set underflow, no pop, -> WAIT_FRAME.
    - frame_start=1 with head.sof=1: pop and output, stay in STREAM.
    - frame_start=1 with head.sof=0 (frame too long): output FILL_COLOR, set underflow, -> RESYNC.
- Priority: when frame_start arrives, the frame_start checks take priority over the ordinary pop rule.
- frame_start without pixel_req is ignored.
- A reset asserted mid-frame drops all contents immediately (asynchronous clear). The state machine restarts in RESYNC.

Optional Feature:
- Macro: VGA_PIXEL_FIFO_STATS_EN.
- When defined, adds output underflow_count [15:0]. It increments, saturating at 16'hFFFF, on every cycle the FILL_COLOR substitution is caused by an error. It resets to 0.
- When undefined, the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - the state encoding enum {RESYNC, WAIT_FRAME, STREAM};
  - the pixel width function 3*CHANNEL_BITS;
  - the default FILL_COLOR constant, reused by vga_top.
- One sub-module: sync_fifo (generic single-clock FIFO with push/pop, full/empty, level).
- The frame-alignment FSM and output register stay in vga_pixel_fifo.

Test Plan:
- Aligned stream: reset, push 8 pixels 0x001..0x008 (sof on the first), pulse frame_start with 8 pixel_req -> pixel_out = 0x001..0x008 one cycle after each request; underflow stays 0.
- Fill to full: push 16 with no requests -> s_ready drops to 0 at level=16. A 17th s_valid is not accepted. One pop -> s_ready returns to 1 the following cycle.
- Underflow: in STREAM, issue pixel_req with the FIFO empty -> pixel_out=0xF0F, underflow=1, state RESYNC. A later sof pixel plus frame_start resumes normal output.
- Resync discard: push 3 non-sof pixels, then a sof pixel 0xABC -> the 3 are discarded. On frame_start, pixel_out=0xABC.
- Short frame: sof arrives at the head mid-frame -> FILL_COLOR until frame_start; then the sof pixel is output; underflow=1.
- Async reset mid-stream with level=10 -> level=0, pixel_out=0, underflow=0 without waiting for a clock edge. With VGA_PIXEL_FIFO_STATS_EN defined, underflow_count also clears to 0.
